// File: rtl/mem_responder.sv
// Single-port memory responder shared by an instruction bus and a data bus.
// One transaction is in flight at a time: IDLE accepts and latches a request,
// WAIT counts out the configured latency, RESP drives a one-cycle response.
//
// Handshake: a requester holds valid (with stable intent) until it sees
// data_ok; addr_ok and data_ok rise together for exactly one cycle on the
// selected port only. Dropping valid before data_ok aborts the transaction
// with no side effects. The requester must drop valid after data_ok or it
// will be treated as a new request on the next IDLE cycle.

package mem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err,
    output state_t     dbg_state_o
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    // Storage starts at zero once at elaboration; reset never touches it.
    logic [63:0] mem_q [DEPTH_WORDS] = '{default: '0};

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        sel_d_q;      // 1: data bus owns the transaction, 0: instruction bus
    logic [63:0] addr_q;
    logic [7:0]  strobe_q;
    logic [63:0] wdata_q;
    logic        err_q;
    ibus_resp_t  iresp_q;
    dbus_resp_t  dresp_q;

    logic             cur_sel_d;
    logic [63:0]      cur_addr;
    logic [7:0]       cur_strobe;
    logic [63:0]      cur_wdata;
    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [63:0]      rd_word;
    logic             any_valid;
    logic             lat_valid;
    logic             fire;
    logic             mem_we;

    assign any_valid = dreq.valid | ireq.valid;
    assign lat_valid = sel_d_q ? dreq.valid : ireq.valid;

    // Transaction view: live inputs while arbitrating in IDLE (needed when
    // LATENCY is 1 and the response fires on the accept edge), latched otherwise.
    always_comb begin
        cur_sel_d  = sel_d_q;
        cur_addr   = addr_q;
        cur_strobe = strobe_q;
        cur_wdata  = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_sel_d  = dreq.valid;
            cur_addr   = dreq.valid ? dreq.addr : ireq.addr;
            cur_strobe = dreq.valid ? dreq.strobe : 8'h00;
            cur_wdata  = dreq.data;
        end
    end

    assign offset   = cur_addr - BASE_ADDR;
    assign idx      = offset[IDX_W+2:3];
    assign in_range = (cur_addr >= BASE_ADDR) && ((offset >> 3) < 64'(DEPTH_WORDS));
    assign rd_word  = in_range ? mem_q[idx] : 64'h0;

    // Response fires on the edge that enters RESP; abort wins over firing.
    always_comb begin
        fire = 1'b0;
        case (state_q)
            ST_IDLE: fire = any_valid && (LATENCY == 1);
            ST_WAIT: fire = lat_valid && (cnt_q == 4'd1);
            default: fire = 1'b0;
        endcase
    end

    // rst gate keeps a write from landing on an edge that coincides with reset.
    assign mem_we = fire && !rst && cur_sel_d && (cur_strobe != 8'h00) && in_range;

    // Control FSM with registered responses and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            sel_d_q  <= 1'b0;
            addr_q   <= 64'h0;
            strobe_q <= 8'h00;
            wdata_q  <= 64'h0;
            err_q    <= 1'b0;
            iresp_q  <= '0;
            dresp_q  <= '0;
        end else begin
            iresp_q <= '0;
            dresp_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        sel_d_q  <= cur_sel_d;
                        addr_q   <= cur_addr;
                        strobe_q <= cur_strobe;
                        wdata_q  <= cur_wdata;
                        cnt_q    <= CNT_INIT;
                        state_q  <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!lat_valid) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (fire) begin
                if (!in_range) begin
                    err_q <= 1'b1;
                end
                if (cur_sel_d) begin
                    dresp_q.addr_ok <= 1'b1;
                    dresp_q.data_ok <= 1'b1;
                    dresp_q.data    <= (cur_strobe == 8'h00) ? rd_word : 64'h0;
                end else begin
                    iresp_q.addr_ok <= 1'b1;
                    iresp_q.data_ok <= 1'b1;
                    iresp_q.data    <= cur_addr[2] ? rd_word[63:32] : rd_word[31:0];
                end
            end
        end
    end

    // Byte-lane write into storage, only on the response edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (cur_strobe[i]) begin
                    mem_q[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request size is informational only; low address bits select within a word.
    logic unused_bits;
    assign unused_bits = ^{dreq.size, offset[63:IDX_W+3], offset[2:0]};

    assign iresp       = iresp_q;
    assign dresp       = dresp_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at default parameters (LATENCY=2).
// Inputs change and outputs are sampled on falling edges.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic       clk;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;
  state_t     dbg_state;

  int n_checks;
  int n_pass;

  mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .ireq        (ireq),
    .iresp       (iresp),
    .dreq        (dreq),
    .dresp       (dresp),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // driver: data bus access, returns data and cycles from request to data_ok (-1 on timeout)
  task automatic d_access(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                          output logic [63:0] rd, output int lat, output logic aok);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.strobe = s;
    dreq.data   = d;
    dreq.size   = 3'd3;
    lat = -1;
    rd  = '0;
    aok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) begin
        lat = c;
        rd  = dresp.data;
        aok = dresp.addr_ok;
        break;
      end
    end
    dreq = '0;
    @(negedge clk);
  endtask

  // driver: instruction bus fetch
  task automatic i_access(input logic [63:0] a, output logic [31:0] rd, output int lat);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (iresp.data_ok === 1'b1) begin
        lat = c;
        rd  = iresp.data;
        break;
      end
    end
    ireq = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ireq = '0;
    dreq = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    n_checks++;
    if (dresp !== '0) $display("FAIL reset_dresp: got %h want 0", dresp);
    else n_pass++;
    n_checks++;
    if (iresp !== '0) $display("FAIL reset_iresp: got %h want 0", iresp);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [63:0] rd;
    int lat;
    logic aok;
    d_access(64'h8000_0008, 8'hFF, 64'h1122334455667788, rd, lat, aok);
    n_checks++;
    if (lat !== 2) $display("FAIL write_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (aok !== 1'b1) $display("FAIL write_addr_ok: got %b want 1", aok);
    else n_pass++;
    n_checks++;
    if (rd !== 64'h0) $display("FAIL write_data_zero: got %h want 0", rd);
    else n_pass++;
    d_access(64'h8000_0008, 8'h00, 64'h0, rd, lat, aok);
    n_checks++;
    if (lat !== 2) $display("FAIL read_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (rd !== 64'h1122334455667788) $display("FAIL read_back: got %h want 1122334455667788", rd);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_in_range: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_strobe();
    logic [63:0] rd;
    int lat;
    logic aok;
    d_access(64'h8000_0008, 8'h01, 64'h0000_0000_0000_00AA, rd, lat, aok);
    d_access(64'h8000_0008, 8'h00, 64'h0, rd, lat, aok);
    n_checks++;
    if (rd !== 64'h11223344556677AA) $display("FAIL byte_strobe: got %h want 11223344556677aa", rd);
    else n_pass++;
  endtask

  task automatic test_ibus_half();
    logic [63:0] rd;
    logic [31:0] ird;
    int lat;
    logic aok;
    d_access(64'h8000_0000, 8'hFF, 64'hDEADBEEF_00000013, rd, lat, aok);
    i_access(64'h8000_0004, ird, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL ibus_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (ird !== 32'hDEADBEEF) $display("FAIL ibus_upper: got %h want deadbeef", ird);
    else n_pass++;
    i_access(64'h8000_0000, ird, lat);
    n_checks++;
    if (ird !== 32'h00000013) $display("FAIL ibus_lower: got %h want 00000013", ird);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int dcyc = -1;
    int icyc = -1;
    logic both = 1'b0;
    logic [63:0] ddata = '0;
    logic [31:0] idata = '0;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0000;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    dreq.size   = 3'd3;
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h8000_0008;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1 && iresp.data_ok === 1'b1) both = 1'b1;
      if (dresp.data_ok === 1'b1 && dcyc < 0) begin
        dcyc  = c;
        ddata = dresp.data;
        dreq  = '0;
      end
      if (iresp.data_ok === 1'b1 && icyc < 0) begin
        icyc  = c;
        idata = iresp.data;
        ireq  = '0;
      end
    end
    n_checks++;
    if (dcyc !== 2) $display("FAIL arb_dbus_cycle: got %0d want 2", dcyc);
    else n_pass++;
    n_checks++;
    if (icyc !== 5) $display("FAIL arb_ibus_cycle: got %0d want 5", icyc);
    else n_pass++;
    n_checks++;
    if (both !== 1'b0) $display("FAIL arb_exclusive: got %b want 0", both);
    else n_pass++;
    n_checks++;
    if (ddata !== 64'hDEADBEEF_00000013) $display("FAIL arb_dbus_data: got %h want deadbeef00000013", ddata);
    else n_pass++;
    n_checks++;
    if (idata !== 32'h556677AA) $display("FAIL arb_ibus_data: got %h want 556677aa", idata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] pattern = '0;
    logic [63:0] last = '0;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0008;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    dreq.size   = 3'd3;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) dreq.addr = 64'h8000_0000;
      if (dresp.data_ok === 1'b1) begin
        pattern[c] = 1'b1;
        last = dresp.data;
      end
      if (c == 8) dreq = '0;
    end
    n_checks++;
    if (pattern !== 10'b0100100100) $display("FAIL b2b_pattern: got %b want 0100100100", pattern);
    else n_pass++;
    n_checks++;
    if (last !== 64'hDEADBEEF_00000013) $display("FAIL b2b_last_data: got %h want deadbeef00000013", last);
    else n_pass++;
  endtask

  task automatic test_latched_addr();
    logic [63:0] rd = '0;
    int lat = -1;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0000;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    dreq.size   = 3'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) dreq.addr = 64'h8000_0008;
      if (dresp.data_ok === 1'b1) begin
        lat = c;
        rd  = dresp.data;
        break;
      end
    end
    dreq = '0;
    @(negedge clk);
    n_checks++;
    if (lat !== 2) $display("FAIL latched_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (rd !== 64'hDEADBEEF_00000013) $display("FAIL latched_addr: got %h want deadbeef00000013", rd);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd;
    int lat;
    logic aok;
    d_access(64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat, aok);
    n_checks++;
    if (lat !== 2) $display("FAIL oor_write_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1) $display("FAIL oor_err_set: got %b want 1", err);
    else n_pass++;
    d_access(64'h8000_1FF8, 8'h00, 64'h0, rd, lat, aok);
    n_checks++;
    if (rd !== 64'h0) $display("FAIL oor_no_alias_write: got %h want 0", rd);
    else n_pass++;
    d_access(64'h8000_2000, 8'h00, 64'h0, rd, lat, aok);
    n_checks++;
    if (lat !== 2 || rd !== 64'h0) $display("FAIL oor_read: got lat %0d data %h want lat 2 data 0", lat, rd);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1) $display("FAIL oor_err_sticky: got %b want 1", err);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) $display("FAIL oor_err_cleared: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [63:0] rd;
    int lat;
    logic aok;
    logic seen = 1'b0;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0008;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hCAFEBABE_CAFEBABE;
    dreq.size   = 3'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) seen = 1'b1;
      if (c == 1) dreq = '0;
      if (c == 2) begin
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL abort_state: got %0d want %0d", dbg_state, ST_IDLE);
        else n_pass++;
      end
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_resp: got %b want 0", seen);
    else n_pass++;
    d_access(64'h8000_0008, 8'h00, 64'h0, rd, lat, aok);
    n_checks++;
    if (rd !== 64'h11223344556677AA) $display("FAIL abort_no_write: got %h want 11223344556677aa", rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_txn();
    logic [63:0] rd;
    int lat;
    logic aok;
    // reset while a write waits
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0008;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hCAFEBABE_CAFEBABE;
    dreq.size   = 3'd3;
    @(negedge clk);
    rst  = 1'b1;
    dreq = '0;
    #1;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL rst_wait_state: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    d_access(64'h8000_0008, 8'h00, 64'h0, rd, lat, aok);
    n_checks++;
    if (rd !== 64'h11223344556677AA) $display("FAIL rst_wait_no_write: got %h want 11223344556677aa", rd);
    else n_pass++;
    // reset while a response is on the bus
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0000;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (dresp.data_ok !== 1'b1) $display("FAIL rst_resp_pre: got %b want 1", dresp.data_ok);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dresp !== '0) $display("FAIL rst_resp_async_clear: got %h want 0", dresp);
    else n_pass++;
    dreq = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b1;
    ireq = '0;
    dreq = '0;
    test_reset();
    test_write_read();
    test_strobe();
    test_ibus_half();
    test_arbitration();
    test_back_to_back();
    test_latched_addr();
    test_out_of_range();
    test_abort();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from accept to response, legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 64-bit storage words.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000: byte address of word 0.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port ireq, input, ibus_req_t {valid, addr[63:0]}: instruction request.
REQ-007 SHALL have port iresp, output, ibus_resp_t {addr_ok, data_ok, data[31:0]}: instruction response.
REQ-008 SHALL have port dreq, input, dbus_req_t {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}: data request.
REQ-009 SHALL have port dresp, output, dbus_resp_t {addr_ok, data_ok, data[63:0]}: data response.
REQ-010 SHALL have port err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-011 SHALL have FSM states IDLE, WAIT and RESP, and SHALL be in IDLE after reset.
REQ-012 IDLE: dreq.valid SHALL win over ireq.valid; the winner is latched (port select, addr, strobe, data), a counter is loaded with LATENCY-1, and the state goes to WAIT, or to RESP if LATENCY==1.
REQ-013 WAIT: the counter SHALL decrement every cycle, and the state SHALL go to RESP on the cycle the counter equals 0.
REQ-014 RESP: the selected port SHALL assert addr_ok=1 and data_ok=1 together for exactly one cycle, then the state returns to IDLE.
REQ-015 Total latency from the valid sample edge to the data_ok cycle SHALL be exactly LATENCY cycles; back-to-back throughput SHALL be one request per LATENCY+1 cycles.
REQ-016 The unselected port SHALL hold addr_ok=0 and data_ok=0; the loser of arbitration SHALL be served next, with no starvation, because dbus goes idle after data_ok.
REQ-017 Word index = (addr-BASE_ADDR)>>3; the address SHALL be in range iff addr>=BASE_ADDR and index<DEPTH_WORDS.
REQ-018 Read (strobe==0): dresp.data SHALL equal the whole 64-bit word; size SHALL be ignored and lane extraction is the requester's job.
REQ-019 Write (strobe!=0): each byte lane i with strobe[i]=1 SHALL be written from data[8i+7:8i] on the RESP edge only; dresp.data SHALL be 0 for writes.
REQ-020 ibus: iresp.data SHALL be word[63:32] if addr[2]=1, else word[31:0]; ibus never writes.
REQ-021 Out-of-range access: a read SHALL return 0, a write SHALL be dropped, the response SHALL still complete normally, and err SHALL be set to 1 until reset.
REQ-022 If the latched port's valid drops in WAIT: the transaction SHALL be aborted, no write performed and no response issued, and the state returns to IDLE next cycle.
REQ-023 If the requester changes addr/data while valid stays high, the latched values SHALL be used.
REQ-024 Response data SHALL be registered, and outputs SHALL be glitch-free from flops.
REQ-025 Memory contents SHALL be zero-initialised at elaboration only, and SHALL be unaffected by rst.

Reset
REQ-026 rst=1 SHALL force state=IDLE, counter=0, err=0, and iresp/dresp addr_ok, data_ok and data all 0 immediately (asynchronously).
REQ-027 Reset asserted in WAIT or RESP SHALL discard the pending transaction, with no memory write, and a pending write SHALL NOT be partially applied.
REQ-028 After rst deasserts, the first valid request SHALL be accepted on the first rising edge.

Verification
REQ-029 Write then read: LATENCY=2, dreq write addr=0x8000_0008, strobe=0xFF, data=0x1122334455667788 -> data_ok 2 cycles later; then a read of the same addr -> dresp.data=0x1122334455667788.
REQ-030 Byte strobe: after REQ-029, write strobe=0x01, data=0xAA -> a read returns 0x11223344556677AA.
REQ-031 Arbitration: ireq and dreq valid in the same cycle -> dresp.data_ok at cycle 2, iresp.data_ok at cycle 5 (LATENCY=2), and never both in one cycle.
REQ-032 ibus half select: word0=0xDEADBEEF_00000013, ireq addr 0x8000_0004 -> iresp.data=0xDEADBEEF; addr 0x8000_0000 -> 0x00000013.
REQ-033 Out of range: a write to 0x7FFF_FFF8 -> data_ok asserted, err=1, memory unchanged; then rst -> err=0.
REQ-034 Abort/reset: drop dreq.valid in WAIT -> no data_ok and no write; assert rst in WAIT during a write -> outputs 0 at once and a later read shows the old value.
